cardinal_pe_nic_master: RTL and testbench



---
 rtl/cardinal_pkg.sv | 14 +
 rtl/cardinal_pe_nic_master.sv | 84 ++++++++
 tb/tb_cardinal_pe_nic_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared NIC register map, master FSM states and default widths
package cardinal_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W = 16;
  localparam logic [1:0] NIC_RX_DATA = 2'b00;
  localparam logic [1:0] NIC_RX_STAT = 2'b01;
  localparam logic [1:0] NIC_TX_DATA = 2'b10;
  localparam logic [1:0] NIC_TX_STAT = 2'b11;
  localparam logic PRIO_TX = 1'b0;
  localparam logic PRIO_RX = 1'b1;
  typedef enum logic [2:0] {
    IDLE, TX_POLL, TX_CHK, TX_STORE, RX_POLL, RX_CHK, RX_LOAD, RX_CAP
  } state_t;
endpackage

// File: rtl/cardinal_pe_nic_master.sv
// cardinal_pe_nic_master: status-polled bridge between TX/RX flit streams and the Cardinal NIC PE port
// clk, reset (sync, active-low); tx_valid/tx_data/tx_ready: flits to store;
// rx_valid/rx_data/rx_ready: captured flits; addr/d_in/d_out/nicEn/nicWrEn: NIC bus;
// tx_cnt/rx_cnt: wrapping counts of completed stores and captured flits.
module cardinal_pe_nic_master
  import cardinal_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic [1:0]        addr,
  output logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] d_out,
  output logic              nicEn,
  output logic              nicWrEn,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  rx_cnt
);
  state_t state;
  logic prio;
  logic rx_want;
  logic stat;
  assign rx_want = !rx_valid;
  assign stat = d_out[DATA_W-1];
  // Bus outputs decode from the state register alone; a CHK state always
  // separates a poll from the access it guards.
  always_comb begin
    nicEn = state inside {TX_POLL, TX_STORE, RX_POLL, RX_LOAD};
    nicWrEn = state == TX_STORE;
    tx_ready = state == TX_STORE;
    addr = state == TX_POLL ? NIC_TX_STAT :
           state == TX_STORE ? NIC_TX_DATA :
           state == RX_POLL ? NIC_RX_STAT : NIC_RX_DATA;
    d_in = state == TX_STORE ? tx_data : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      prio <= PRIO_TX;
      rx_valid <= 1'b0;
      rx_data <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: state <= (tx_valid && (prio == PRIO_TX || !rx_want)) ? TX_POLL :
                       rx_want ? RX_POLL : IDLE;
        TX_POLL: state <= TX_CHK;
        TX_CHK: begin
          state <= stat ? IDLE : TX_STORE;
          if (stat) prio <= PRIO_RX;
        end
        TX_STORE: begin
          state <= IDLE;
          tx_cnt <= tx_cnt + 1'b1;
          prio <= PRIO_RX;
        end
        RX_POLL: state <= RX_CHK;
        RX_CHK: begin
          state <= stat ? RX_LOAD : IDLE;
          if (!stat) prio <= PRIO_TX;
        end
        RX_LOAD: state <= RX_CAP;
        RX_CAP: begin
          state <= IDLE;
          rx_data <= d_out;
          rx_valid <= 1'b1;
          rx_cnt <= rx_cnt + 1'b1;
          prio <= PRIO_TX;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cardinal_pe_nic_master.sv
// tb_cardinal_pe_nic_master: NIC model plus TX/RX scoreboards around the PE master
module tb_cardinal_pe_nic_master;
  localparam int DW = 64;
  localparam int CW = 8;
  logic clk = 0, reset = 0, tx_valid = 0, rx_ready = 0, net_ro = 1;
  logic [DW-1:0] tx_data = '0;
  logic tx_ready, rx_valid, nicEn, nicWrEn;
  logic [DW-1:0] rx_data, d_in, d_out;
  logic [1:0] addr;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic tx_full = 0, rx_full = 0;
  logic [DW-1:0] tx_buf = '0, rx_buf = '0, inj_val = 64'hF0E1D2C3B4A59687;
  logic [DW-1:0] tx_q[$], rx_q[$];
  int errors = 0, checks = 0, n_st = 0, n_inj = 0, inj_limit = 0, cyc = 0;
  int last_poll = 0, n_rxacc = 0, busy = 0, n_txst = 0, n_rxcap = 0;
  int base_t = 0, base_r = 0, maxd = 0;
  bit arb_on = 0, arb_based = 0;
  logic p1_en = 0, p1_wr = 0, p2_en = 0, p2_wr = 0, p1_msb = 0, p_rxv = 0;
  logic [1:0] p1_addr = 0, p2_addr = 0;

  cardinal_pe_nic_master #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // NIC model: registered loads, one-flit TX/RX buffers, network drain and router inject
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      tx_full <= 0;
      rx_full <= 0;
      d_out <= '0;
      tx_q.delete();
      rx_q.delete();
    end else begin
      if (nicEn && !nicWrEn)
        d_out <= addr == 2'b00 ? rx_buf : addr == 2'b01 ? {rx_full, 63'b0} :
                 addr == 2'b11 ? {tx_full, 63'b0} : 64'h0;
      if (nicEn && !nicWrEn && addr == 2'b00) rx_full <= 0;
      else if (n_inj < inj_limit && !rx_full) begin
        rx_full <= 1;
        rx_buf <= inj_val;
        rx_q.push_back(inj_val);
        inj_val <= {$urandom(), $urandom()};
        n_inj <= n_inj + 1;
      end
      if (nicEn && nicWrEn && addr == 2'b10) begin
        tx_full <= 1;
        tx_buf <= d_in;
      end else if (net_ro && tx_full) begin
        tx_full <= 0;
        check("tx_q_nonempty", 64'(tx_q.size() != 0), 64'd1);
        if (tx_q.size() != 0) check("net_do", tx_buf, tx_q.pop_front());
      end
    end
  end

  // Bus protocol monitor, RX sink scoreboard and arbitration tracking
  always @(negedge clk) begin
    if (nicEn) check("nic_b2b", 64'(p1_en), 64'd0);
    if (nicEn && nicWrEn)
      check("st_after_poll", 64'({p2_en, p2_wr, p2_addr, p1_en, p1_msb}), 64'(6'b101100));
    if (nicEn && !nicWrEn && addr == 2'b00)
      check("ld_after_poll", 64'({p2_en, p2_wr, p2_addr, p1_en, p1_msb}), 64'(6'b100101));
    if (p1_en && !p1_wr && p1_addr == 2'b11 && d_out[63]) busy <= busy + 1;
    if (nicEn && !nicWrEn && addr == 2'b01) last_poll <= cyc;
    if (nicEn && !nicWrEn && !addr[1]) n_rxacc <= n_rxacc + 1;
    if (rx_valid && rx_ready) begin
      check("rx_q_nonempty", 64'(rx_q.size() != 0), 64'd1);
      if (rx_q.size() != 0) check("rx_data", rx_data, rx_q.pop_front());
    end
    if (tx_ready) n_txst <= n_txst + 1;
    if (rx_valid && !p_rxv) n_rxcap <= n_rxcap + 1;
    if (arb_on && !arb_based && tx_ready) begin
      arb_based <= 1;
      base_t <= n_txst + 1;
      base_r <= n_rxcap;
    end
    if (arb_on && arb_based && (n_txst - base_t) - (n_rxcap - base_r) > maxd)
      maxd <= (n_txst - base_t) - (n_rxcap - base_r);
    if (arb_on && arb_based && (n_rxcap - base_r) - (n_txst - base_t) > maxd)
      maxd <= (n_rxcap - base_r) - (n_txst - base_t);
    p2_en <= p1_en;
    p2_wr <= p1_wr;
    p2_addr <= p1_addr;
    p1_en <= nicEn;
    p1_wr <= nicWrEn;
    p1_addr <= addr;
    p1_msb <= d_out[63];
    p_rxv <= rx_valid;
  end

  task automatic wait_ready(input logic [63:0] d, input bit count);
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        got = 1;
        break;
      end
    end
    check("tx_ready_seen", 64'(got), 64'd1);
    if (got) begin
      check("st_data", d_in, d);
      check("st_bus", 64'({addr, nicWrEn, nicEn}), 64'(4'b1011));
      if (count) n_st++;
    end
    @(posedge clk);
    #1 tx_valid = 0;
  endtask

  task automatic send(input logic [63:0] d);
    tx_q.push_back(d);
    tx_data = d;
    tx_valid = 1;
    wait_ready(d, 1);
  endtask

  initial begin
    bit got;
    int hits, acc0;
    logic [63:0] b;
    tx_data = 64'h0123456789ABCDEE;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ctl", 64'({tx_ready, rx_valid, nicEn, nicWrEn, addr, tx_cnt, rx_cnt}), 64'd0);
      check("rst_rxd", rx_data, 64'd0);
      check("rst_din", d_in, 64'd0);
    end
    reset = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nicEn) begin
        got = 1;
        break;
      end
    end
    check("first_acc_seen", 64'(got), 64'd1);
    check("first_acc", 64'({nicWrEn, addr}), 64'(3'b001));

    send(64'h0123456789ABCDEE);
    @(negedge clk);
    check("tx_cnt_1", 64'(tx_cnt), 64'(n_st % 256));
    repeat (2) @(negedge clk);
    check("tx_drained", 64'(tx_q.size()), 64'd0);

    net_ro = 0;
    send(64'hA5A5_0000_1111_2222);
    b = 64'h5A5A_3333_4444_5555;
    tx_q.push_back(b);
    tx_data = b;
    tx_valid = 1;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_ready) hits++;
    end
    check("bp_no_ready", 64'(hits), 64'd0);
    check("bp_busy_seen", 64'(busy > 0), 64'd1);
    check("bp_tx_cnt", 64'(tx_cnt), 64'(n_st % 256));
    @(posedge clk);
    #1 net_ro = 1;
    wait_ready(b, 1);
    @(negedge clk);
    check("bp_tx_cnt_after", 64'(tx_cnt), 64'(n_st % 256));
    repeat (2) @(negedge clk);
    check("bp_drained", 64'(tx_q.size()), 64'd0);

    @(posedge clk);
    #1 inj_limit = 1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        got = 1;
        break;
      end
    end
    check("rx_seen", 64'(got), 64'd1);
    if (got) check("rx_lat", 64'(cyc - last_poll), 64'd4);
    check("rx_cnt_1", 64'(rx_cnt), 64'd1);
    check("net_ri", 64'(rx_full), 64'd0);
    acc0 = n_rxacc;
    repeat (20) @(negedge clk);
    check("rx_hold_acc", 64'(n_rxacc - acc0), 64'd0);
    check("rx_hold_valid", 64'(rx_valid), 64'd1);
    @(posedge clk);
    #1 rx_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("rx_drop", 64'(rx_valid), 64'd0);
    check("rx_q_empty", 64'(rx_q.size()), 64'd0);

    @(posedge clk);
    #1 begin
      inj_limit = 1000;
      arb_on = 1;
    end
    for (int i = 0; i < 100; i++) send({$urandom(), $urandom()});
    arb_on = 0;
    inj_limit = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rx_full && !rx_valid && rx_q.size() == 0) begin
        got = 1;
        break;
      end
    end
    check("arb_rx_drain", 64'(got), 64'd1);
    check("arb_max_diff", 64'(maxd <= 1), 64'd1);
    check("arb_rx_progress", 64'(n_rxcap - base_r >= 95), 64'd1);
    check("arb_rx_cnt", 64'(rx_cnt), 64'(n_inj % 256));
    check("arb_tx_cnt", 64'(tx_cnt), 64'(n_st % 256));

    while (n_st % 256 != 0) send({$urandom(), $urandom()});
    @(negedge clk);
    check("tx_cnt_wrap", 64'(tx_cnt), 64'd0);

    b = 64'hDEAD_BEEF_CAFE_F00D;
    tx_q.push_back(b);
    tx_data = b;
    tx_valid = 1;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        got = 1;
        break;
      end
    end
    check("mid_store_seen", 64'(got), 64'd1);
    reset = 0;
    @(negedge clk);
    check("mid_rst_ctl", 64'({tx_ready, rx_valid, nicEn, nicWrEn, addr, tx_cnt, rx_cnt}), 64'd0);
    check("mid_rst_din", d_in, 64'd0);
    tx_valid = 0;
    @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    check("mid_rst_txbuf", 64'(tx_full), 64'd0);
    check("mid_rst_tx_cnt", 64'(tx_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
